// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc window sequencer: layer configuration, FSM states
// and the read-set sizing helper.
package qracc_pkg;
  localparam int DIM_W = 16;
  localparam int FLT_W = 8;

  typedef struct packed {
    logic [DIM_W-1:0] dimx;
    logic [DIM_W-1:0] dimy;
    logic [DIM_W-1:0] channels;
    logic [FLT_W-1:0] fx;
    logic [FLT_W-1:0] fy;
    logic [FLT_W-1:0] sx;
    logic [FLT_W-1:0] sy;
    logic [FLT_W-1:0] pad_y;
    logic [DIM_W-1:0] odimx;
    logic [DIM_W-1:0] odimy;
    logic [DIM_W-1:0] k;
  } window_cfg_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} seq_state_e;

  function automatic logic [DIM_W-1:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return DIM_W'((num + den - 32'd1) / den);
  endfunction
endpackage

// File: rtl/qracc_window_counter.sv
// Nested beat counter: rs innermost, then fy, ox, oy. Each level wraps at its
// max and carries into the next; last_o flags the final beat of the layer.
module qracc_window_counter
  import qracc_pkg::*;
#(
  parameter int CW = DIM_W
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clear_i,
  input  logic          advance_i,
  input  logic [CW-1:0] rs_max_i,
  input  logic [CW-1:0] fy_max_i,
  input  logic [CW-1:0] ox_max_i,
  input  logic [CW-1:0] oy_max_i,
  output logic [CW-1:0] rs_o,
  output logic [CW-1:0] fy_o,
  output logic [CW-1:0] ox_o,
  output logic [CW-1:0] oy_o,
  output logic          last_o
);
  logic [CW-1:0] rs_q, rs_d, fy_q, fy_d, ox_q, ox_d, oy_q, oy_d;
  logic rs_wrap, fy_wrap, ox_wrap, oy_wrap;

  assign rs_wrap = (rs_q == rs_max_i);
  assign fy_wrap = (fy_q == fy_max_i);
  assign ox_wrap = (ox_q == ox_max_i);
  assign oy_wrap = (oy_q == oy_max_i);

  always_comb begin
    rs_d = rs_q;
    fy_d = fy_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (clear_i) begin
      rs_d = '0;
      fy_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (advance_i) begin
      rs_d = rs_wrap ? '0 : rs_q + CW'(1);
      if (rs_wrap) begin
        fy_d = fy_wrap ? '0 : fy_q + CW'(1);
        if (fy_wrap) begin
          ox_d = ox_wrap ? '0 : ox_q + CW'(1);
          if (ox_wrap) oy_d = oy_wrap ? '0 : oy_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rs_q <= '0;
      fy_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      rs_q <= rs_d;
      fy_q <= fy_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
    end
  end

  assign rs_o   = rs_q;
  assign fy_o   = fy_q;
  assign ox_o   = ox_q;
  assign oy_o   = oy_q;
  assign last_o = rs_wrap & fy_wrap & ox_wrap & oy_wrap;
endmodule

// File: rtl/qracc_window_sequencer.sv
// Walks output windows of a conv layer, issuing activation read beats to the
// feature loader and tracking ofmap writebacks until the layer is complete.
module qracc_window_sequencer
  import qracc_pkg::*;
#(
  parameter int addrWidth                 = 16,
  parameter int internalInterfaceElements = 16,
  parameter int maxFilterSize             = 7
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  window_cfg_t          cfg,
  input  logic                 start,
  input  logic                 clear,
  input  logic [addrWidth-1:0] ifmap_base,
  input  logic [addrWidth-1:0] ofmap_base,
  output logic                 beat_valid,
  input  logic                 beat_ready,
  output logic [addrWidth-1:0] rd_addr,
  output logic [addrWidth-1:0] fl_addr,
  output logic                 pad_beat,
  output logic                 window_done,
  input  logic                 wb_valid,
  output logic [addrWidth-1:0] wb_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 wb_overflow
);
  localparam int E = internalInterfaceElements;

  seq_state_e           state_q, state_d;
  window_cfg_t          cfg_q, cfg_d;
  logic [addrWidth-1:0] ibase_q, ibase_d, obase_q, obase_d, wb_ptr_q, wb_ptr_d;
  logic [DIM_W-1:0]     rs_max_q, rs_max_d;
  logic [31:0]          wb_cnt_q, wb_cnt_d, wb_tgt;
  logic                 ovf_q, ovf_d;
  logic                 load, fire, last, wb_live;
  logic [DIM_W-1:0]     rs, fy, ox, oy, num_rs;
  logic [FLT_W-1:0]     fx_c, fy_c;
  int                   row, rd_off, fl_off;

  // Zero-sized filters degenerate to 1; oversize ones saturate at the supported max.
  function automatic logic [FLT_W-1:0] clamp_flt(input logic [FLT_W-1:0] f);
    if (f == '0) return FLT_W'(1);
    if (int'(f) > maxFilterSize) return FLT_W'(maxFilterSize);
    return f;
  endfunction

  assign fx_c    = clamp_flt(cfg.fx);
  assign fy_c    = clamp_flt(cfg.fy);
  assign num_rs  = ceil_div(32'(cfg.channels) * 32'(fx_c), 32'(E));
  assign load    = (state_q == S_IDLE) && start && !clear;
  assign fire    = beat_valid && beat_ready;
  assign wb_live = wb_valid && (state_q != S_IDLE);
  assign wb_tgt  = 32'(cfg_q.odimx) * 32'(cfg_q.odimy);

  qracc_window_counter #(.CW(DIM_W)) u_cnt (
    .clk      (clk),
    .nrst     (nrst),
    .clear_i  (clear | load),
    .advance_i(fire),
    .rs_max_i (rs_max_q),
    .fy_max_i (DIM_W'(cfg_q.fy) - DIM_W'(1)),
    .ox_max_i (cfg_q.odimx - DIM_W'(1)),
    .oy_max_i (cfg_q.odimy - DIM_W'(1)),
    .rs_o     (rs),
    .fy_o     (fy),
    .ox_o     (ox),
    .oy_o     (oy),
    .last_o   (last)
  );

  always_comb begin
    cfg_d    = cfg_q;
    ibase_d  = ibase_q;
    obase_d  = obase_q;
    rs_max_d = rs_max_q;
    if (load) begin
      cfg_d    = cfg;
      cfg_d.fx = fx_c;
      cfg_d.fy = fy_c;
      ibase_d  = ifmap_base;
      obase_d  = ofmap_base;
      rs_max_d = (num_rs == '0) ? '0 : num_rs - DIM_W'(1);
    end
  end

  // Writeback count saturates at the target; anything beyond is flagged instead.
  always_comb begin
    wb_ptr_d = wb_ptr_q;
    wb_cnt_d = wb_cnt_q;
    ovf_d    = ovf_q;
    if (load) begin
      wb_ptr_d = '0;
      wb_cnt_d = '0;
    end else if (wb_live) begin
      wb_ptr_d = wb_ptr_q + addrWidth'(cfg_q.k);
      if (wb_cnt_q == wb_tgt) ovf_d = 1'b1;
      else                    wb_cnt_d = wb_cnt_q + 32'd1;
    end
    if (clear) begin
      wb_ptr_d = '0;
      wb_cnt_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (load) state_d = S_RUN;
      S_RUN:   if (fire && last) state_d = S_DRAIN;
      S_DRAIN: if (wb_cnt_d == wb_tgt) begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      ibase_q  <= '0;
      obase_q  <= '0;
      rs_max_q <= '0;
      wb_ptr_q <= '0;
      wb_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      ibase_q  <= ibase_d;
      obase_q  <= obase_d;
      rs_max_q <= rs_max_d;
      wb_ptr_q <= wb_ptr_d;
      wb_cnt_q <= wb_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Signed row so rows above the image (top padding) come out negative.
  always_comb begin
    row    = int'(oy) * int'(cfg_q.sy) + int'(fy) - int'(cfg_q.pad_y);
    rd_off = int'(cfg_q.channels) * int'(cfg_q.dimx) * row
           + int'(cfg_q.channels) * int'(ox) * int'(cfg_q.sx) + int'(rs) * E;
    fl_off = int'(fy) * int'(cfg_q.channels) * int'(cfg_q.fx) + int'(rs) * E;
  end

  assign beat_valid  = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign rd_addr     = beat_valid ? ibase_q + addrWidth'(rd_off) : '0;
  assign fl_addr     = beat_valid ? addrWidth'(fl_off) : '0;
  assign pad_beat    = beat_valid && ((row < 0) || (row >= int'(cfg_q.dimy)));
  assign window_done = beat_valid && (fy == DIM_W'(cfg_q.fy) - DIM_W'(1)) && (rs == rs_max_q);
  assign wb_addr     = obase_q + wb_ptr_q;
  assign wb_overflow = ovf_q;
endmodule

// File: tb/tb_qracc_window_sequencer.sv
// Scoreboard bench for qracc_window_sequencer: stimulus queues expected beats
// and writeback addresses, a negedge monitor pops and compares them.
module tb_qracc_window_sequencer;
  import qracc_pkg::*;
  localparam int AW = 16;

  logic          clk = 1'b0, nrst = 1'b0, start = 1'b0, clear = 1'b0;
  logic          beat_ready = 1'b1, wb_valid = 1'b0;
  window_cfg_t   cfg = '0;
  logic [AW-1:0] ifmap_base = '0, ofmap_base = '0;
  logic          beat_valid, pad_beat, window_done, busy, done, wb_overflow;
  logic [AW-1:0] rd_addr, fl_addr, wb_addr;

  qracc_window_sequencer #(.addrWidth(AW), .internalInterfaceElements(16), .maxFilterSize(7)) dut (
    .clk(clk), .nrst(nrst), .cfg(cfg), .start(start), .clear(clear),
    .ifmap_base(ifmap_base), .ofmap_base(ofmap_base),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .rd_addr(rd_addr), .fl_addr(fl_addr), .pad_beat(pad_beat), .window_done(window_done),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy(busy), .done(done), .wb_overflow(wb_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [AW-1:0] fl;
    logic          pad;
    logic          wd;
  } beat_t;

  beat_t         beat_q[$];
  logic [AW-1:0] wb_q[$];
  beat_t         e;
  int  checks = 0, errors = 0, beats_seen = 0, done_seen = 0;
  bit  chk_beats = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic window_cfg_t mk(input int dx, input int dy, input int c, input int fx, input int fy,
                                     input int s, input int pad, input int odx, input int ody, input int k);
    window_cfg_t r;
    r.dimx = DIM_W'(dx); r.dimy = DIM_W'(dy); r.channels = DIM_W'(c);
    r.fx = FLT_W'(fx); r.fy = FLT_W'(fy); r.sx = FLT_W'(s); r.sy = FLT_W'(s);
    r.pad_y = FLT_W'(pad); r.odimx = DIM_W'(odx); r.odimy = DIM_W'(ody); r.k = DIM_W'(k);
    return r;
  endfunction

  task automatic push_beat(input int rd, input int fl, input bit pad, input bit wd);
    beat_t b;
    b.rd = AW'(rd); b.fl = AW'(fl); b.pad = pad; b.wd = wd;
    beat_q.push_back(b);
  endtask

  // Reference beat stream for configurations with E = 16.
  task automatic push_model(input window_cfg_t c, input int ib);
    int r, row, cc, dx;
    cc = int'(c.channels);
    dx = int'(c.dimx);
    r  = (cc * int'(c.fx) + 15) / 16;
    for (int oy = 0; oy < int'(c.odimy); oy++)
      for (int ox = 0; ox < int'(c.odimx); ox++)
        for (int fy = 0; fy < int'(c.fy); fy++)
          for (int rs = 0; rs < r; rs++) begin
            row = oy * int'(c.sy) + fy - int'(c.pad_y);
            push_beat(ib + cc * dx * row + cc * ox * int'(c.sx) + rs * 16,
                      fy * cc * int'(c.fx) + rs * 16,
                      (row < 0) || (row >= int'(c.dimy)),
                      (fy == int'(c.fy) - 1) && (rs == r - 1));
          end
  endtask

  // Runs one complete layer: issue start, optionally stall mid-window, wait for
  // drain, then retire every writeback and require done on exactly the last one.
  task automatic run_layer(input window_cfg_t c, input int ib, input int ob, input int nbeats, input bit stall);
    int n, nwb;
    nwb = int'(c.odimx) * int'(c.odimy);
    beats_seen = 0;
    cfg = c; ifmap_base = AW'(ib); ofmap_base = AW'(ob);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg = '1; ifmap_base = ~AW'(ib); ofmap_base = ~AW'(ob);
    if (stall) begin
      repeat (4) tick();
      beat_ready = 1'b0;
      repeat (5) tick();
      beat_ready = 1'b1;
    end
    n = 0;
    while (!(busy && !beat_valid) && n < 500) begin
      tick();
      n++;
    end
    check("drain_reached", 32'(n < 500), 32'd1);
    check("beat_count", 32'(beats_seen), 32'(nbeats));
    check("beat_queue_empty", 32'(beat_q.size()), 32'd0);
    for (int i = 0; i < nwb; i++) begin
      wb_valid = 1'b1;
      wb_q.push_back(AW'(ob + i * int'(c.k)));
      @(negedge clk);
      check("done_on_last_wb", 32'(done), 32'(i == nwb - 1));
      tick();
    end
    wb_valid = 1'b0;
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (done) done_seen++;
      if (beat_valid && chk_beats) begin
        if (beat_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else begin
          e = beat_q[0];
          if (!e.pad) check("rd_addr", 32'(rd_addr), 32'(e.rd));
          check("fl_addr", 32'(fl_addr), 32'(e.fl));
          check("pad_beat", 32'(pad_beat), 32'(e.pad));
          check("window_done", 32'(window_done), 32'(e.wd));
          if (beat_ready) begin
            void'(beat_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (wb_valid) begin
        if (wb_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
        else check("wb_addr", 32'(wb_addr), 32'(wb_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    window_cfg_t c1, c2, c3;
    int d0;
    logic act;
    c1 = mk(4, 4, 4, 3, 3, 1, 0, 2, 2, 4);
    c2 = mk(4, 4, 16, 3, 2, 1, 0, 1, 2, 8);
    c3 = mk(4, 3, 4, 1, 3, 1, 1, 1, 3, 4);

    repeat (3) @(posedge clk);
    #1;
    check("rst_beat_valid", 32'(beat_valid), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_flags", 32'({pad_beat, window_done, wb_overflow}), 32'd0);
    check("rst_addrs", 32'({rd_addr, fl_addr}), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    nrst = 1'b1;
    tick();

    // Basic layer, one read set per filter row.
    push_model(c1, 'h100);
    run_layer(c1, 'h100, 'h1000, 12, 1'b0);

    // Three read sets per filter row (hand-computed).
    push_beat('h200,  0, 0, 0); push_beat('h210, 16, 0, 0); push_beat('h220, 32, 0, 0);
    push_beat('h240, 48, 0, 0); push_beat('h250, 64, 0, 0); push_beat('h260, 80, 0, 1);
    push_beat('h240,  0, 0, 0); push_beat('h250, 16, 0, 0); push_beat('h260, 32, 0, 0);
    push_beat('h280, 48, 0, 0); push_beat('h290, 64, 0, 0); push_beat('h2A0, 80, 0, 1);
    run_layer(c2, 'h200, 'h2000, 12, 1'b0);

    // Top and bottom padding rows (hand-computed).
    push_beat(0,      0, 1, 0); push_beat('h300, 4, 0, 0); push_beat('h310, 8, 0, 1);
    push_beat('h300,  0, 0, 0); push_beat('h310, 4, 0, 0); push_beat('h320, 8, 0, 1);
    push_beat('h310,  0, 0, 0); push_beat('h320, 4, 0, 0); push_beat(0,      8, 1, 1);
    run_layer(c3, 'h300, 'h3000, 9, 1'b0);

    // Backpressure in the middle of a window.
    push_model(c1, 'h400);
    run_layer(c1, 'h400, 'h4000, 12, 1'b1);

    // Excess writebacks while running, then clear.
    chk_beats = 1'b0;
    d0 = done_seen;
    cfg = c1; ifmap_base = 'h500; ofmap_base = 'h5000;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1;
      wb_q.push_back(AW'('h5000 + i * 4));
      tick();
      if (i == 3) check("no_ovf_at_target", 32'(wb_overflow), 32'd0);
    end
    wb_valid = 1'b0;
    check("ovf_set", 32'(wb_overflow), 32'd1);
    check("ovf_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", 32'(wb_overflow), 32'd0);
    check("clear_idle", 32'({busy, beat_valid}), 32'd0);
    check("clear_no_done", 32'(done_seen), 32'(d0));
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("clear_beats_start", 32'(busy), 32'd0);

    // Reset in the middle of a layer.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    check("mid_rst_valid_busy", 32'({beat_valid, busy, done}), 32'd0);
    check("mid_rst_addrs", 32'({rd_addr, fl_addr}), 32'd0);
    check("mid_rst_wb", 32'({wb_addr, pad_beat, window_done, wb_overflow}), 32'd0);
    tick();
    nrst = 1'b1;
    d0 = done_seen;
    act = 1'b0;
    repeat (10) begin
      tick();
      act = act | beat_valid | busy | done;
    end
    check("post_rst_quiet", 32'(act), 32'd0);
    check("post_rst_no_done", 32'(done_seen), 32'(d0));
    chk_beats = 1'b1;
    push_model(c1, 'h600);
    run_layer(c1, 'h600, 'h6000, 12, 1'b0);

    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
